// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared constants, requester IDs and starve counter sizing
// for the boot data memory port A arbiter.
package bram_arb_pkg;

    localparam int LANES_DEF = 4;
    localparam int DATA_W    = 8 * LANES_DEF;

    typedef enum logic {
        REQ_CPU    = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_e;

    function automatic int starve_w(input int starve);
        return $clog2(starve + 1);
    endfunction

endpackage

// File: rtl/bram_arb_prio.sv
// bram_arb_prio: fixed CPU priority with a starvation guard that hands the
// port to the loader after STARVE consecutive CPU wins while it waits.
module bram_arb_prio
    import bram_arb_pkg::*;
#(
    parameter int STARVE = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int CW = starve_w(STARVE);

    logic [CW-1:0] starve_cnt;
    logic          sat;

    always_comb begin
        sat             = starve_cnt == CW'(STARVE);
        gnt[REQ_CPU]    = req[REQ_CPU] & ~(req[REQ_LOADER] & sat);
        gnt[REQ_LOADER] = req[REQ_LOADER] & ~gnt[REQ_CPU];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (gnt[REQ_LOADER] || !req[REQ_LOADER])
            starve_cnt <= '0;
        else if (gnt[REQ_CPU] && !sat)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares boot memory port A between the CPU (r0) and the
// loader (r1); muxes address/data/lane enables and routes read data back.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR   = 12,
    parameter int LANES  = LANES_DEF,
    parameter int STARVE = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               r0_req,
    input  logic               r0_we,
    input  logic [LANES-1:0]   r0_be,
    input  logic [ADDR-1:0]    r0_addr,
    input  logic [8*LANES-1:0] r0_wdata,
    output logic               r0_gnt,
    output logic               r0_rvalid,
    output logic [8*LANES-1:0] r0_rdata,
    input  logic               r1_req,
    input  logic               r1_we,
    input  logic [LANES-1:0]   r1_be,
    input  logic [ADDR-1:0]    r1_addr,
    input  logic [8*LANES-1:0] r1_wdata,
    output logic               r1_gnt,
    output logic               r1_rvalid,
    output logic [8*LANES-1:0] r1_rdata,
    output logic [ADDR-1:0]    ram_addr,
    output logic [LANES-1:0]   ram_we,
    output logic [8*LANES-1:0] ram_wdata,
    input  logic [8*LANES-1:0] ram_rdata
);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             sel;
    logic             we_g;
    logic [LANES-1:0] be_g;
    logic [ADDR-1:0]  last_addr;
    logic             rd_pending;
    req_id_e          rd_owner;

    // Assertion is immediate; release waits two edges so every flop leaves
    // reset on the same clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    bram_arb_prio #(.STARVE(STARVE)) u_prio (
        .clk     (clk),
        .reset_n (rst_int_n),
        .req     ({r1_req, r0_req} & {2{rst_int_n}}),
        .gnt     (gnt)
    );

    always_comb begin
        r0_gnt    = gnt[REQ_CPU];
        r1_gnt    = gnt[REQ_LOADER];
        any_gnt   = |gnt;
        sel       = gnt[REQ_LOADER];
        we_g      = sel ? r1_we : r0_we;
        be_g      = sel ? r1_be : r0_be;
        ram_addr  = any_gnt ? (sel ? r1_addr : r0_addr) : last_addr;
        ram_wdata = sel ? r1_wdata : r0_wdata;
        ram_we    = be_g & {LANES{we_g & any_gnt}};
        r0_rvalid = rd_pending & (rd_owner == REQ_CPU);
        r1_rvalid = rd_pending & (rd_owner == REQ_LOADER);
        r0_rdata  = ram_rdata & {(8*LANES){r0_rvalid}};
        r1_rdata  = ram_rdata & {(8*LANES){r1_rvalid}};
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            last_addr  <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= REQ_CPU;
        end else begin
            if (any_gnt)
                last_addr <= ram_addr;
            rd_pending <= any_gnt & ~we_g;
            rd_owner   <= sel ? REQ_LOADER : REQ_CPU;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and random stimulus against a lane RAM
// environment model, checked every cycle by a behavioural reference.
module tb_bram_port_arbiter;

    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [3:0]  r0_be, r1_be;
    logic [11:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic [11:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    bram_port_arbiter #(.ADDR(12), .LANES(4), .STARVE(STARVE)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_be(r0_be), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_be(r1_be), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return {a[7:0] ^ 8'h5A, ~a[7:0], a[7:0], 8'hC3};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lane RAMs: registered read address, per-lane writes, preload from init_val.
    bit [31:0]   mem [4096];
    bit [3:0]    wr  [4096];
    logic [11:0] addr_q = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) begin
                mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                wr[ram_addr][i]         <= 1'b1;
            end
        addr_q <= ram_addr;
    end

    always_comb begin
        ram_rdata = init_val(addr_q);
        for (int i = 0; i < 4; i++)
            if (wr[addr_q][i])
                ram_rdata[8*i +: 8] = mem[addr_q][8*i +: 8];
    end

    // Edges seen since reset release; the port opens after the second.
    int rel;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rel <= 0;
        else if (rel < 2)
            rel <= rel + 1;
    end

    // Reference model and the single per-cycle compare process.
    bit [31:0]   shadow [4096];
    int          m_wait, w1;
    bit          m_pend, m_own;
    logic [31:0] m_data;
    logic [11:0] m_last;

    initial begin
        bit          e0, e1, gwe;
        logic [11:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gw;
        for (int i = 0; i < 4096; i++)
            shadow[i] = init_val(12'(i));
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_wait = 0; m_pend = 0; m_own = 0; m_last = '0; w1 = 0;
                chk("rst_gnt", 64'({r1_gnt, r0_gnt}), 64'd0);
                chk("rst_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'd0);
                chk("rst_ram_we", 64'(ram_we), 64'd0);
                chk("rst_ram_addr", 64'(ram_addr), 64'd0);
                chk("rst_rdata", {r1_rdata, r0_rdata}, 64'd0);
            end else begin
                e0  = (rel >= 2) && r0_req && !(r1_req && m_wait == STARVE);
                e1  = (rel >= 2) && r1_req && !e0;
                ga  = e1 ? r1_addr : r0_addr;
                gwe = e1 ? r1_we : r0_we;
                gbe = e1 ? r1_be : r0_be;
                gw  = e1 ? r1_wdata : r0_wdata;
                chk("gnt", 64'({r1_gnt, r0_gnt}), 64'({e1, e0}));
                chk("rvalid", 64'({r1_rvalid, r0_rvalid}), 64'({m_pend && m_own, m_pend && !m_own}));
                chk("r0_rdata", 64'(r0_rdata), 64'((m_pend && !m_own) ? m_data : 32'd0));
                chk("r1_rdata", 64'(r1_rdata), 64'((m_pend && m_own) ? m_data : 32'd0));
                chk("ram_addr", 64'(ram_addr), 64'((e0 || e1) ? ga : m_last));
                chk("ram_we", 64'(ram_we), 64'(((e0 || e1) && gwe) ? gbe : 4'd0));
                if (e0 || e1)
                    chk("ram_wdata", 64'(ram_wdata), 64'(gw));
                w1 = (r1_req && rel >= 2) ? w1 + 1 : 0;
                if (e1) begin
                    n_cmp++;
                    if (w1 > STARVE + 1) begin
                        n_bad++;
                        $display("FAIL loader_wait: got %0d cycles limit %0d", w1, STARVE + 1);
                    end
                    w1 = 0;
                end
                m_pend = (e0 || e1) && !gwe;
                m_own  = e1;
                m_data = shadow[ga];
                if ((e0 || e1) && gwe)
                    for (int i = 0; i < 4; i++)
                        if (gbe[i])
                            shadow[ga][8*i +: 8] = gw[8*i +: 8];
                if (e0 || e1)
                    m_last = ga;
                if (e0 && r1_req)
                    m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
                else if (e1 || !r1_req)
                    m_wait = 0;
            end
        end
    end

    // Stimulus side: one clock cycle, sampling what the requesters observe.
    bit          g0, g1, rv0, rv1;
    logic [31:0] rd0;
    logic [3:0]  we_s;

    task automatic cyc();
        @(negedge clk);
        g0 = r0_gnt; g1 = r1_gnt; rv0 = r0_rvalid; rv1 = r1_rvalid;
        rd0 = r0_rdata; we_s = ram_we;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit rq, input bit we, input logic [3:0] be,
                        input logic [11:0] a, input logic [31:0] d);
        r0_req = rq; r0_we = we; r0_be = be; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input bit rq, input bit we, input logic [3:0] be,
                        input logic [11:0] a, input logic [31:0] d);
        r1_req = rq; r1_we = we; r1_be = be; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        set0(1, 0, 4'h0, 12'h000, 32'h0);
        set1(1, 0, 4'h0, 12'h000, 32'h0);
        repeat (3) cyc();
        chk("hold_rst_gnt", 64'({g1, g0}), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();
        chk("rel_gnt_edge0", 64'(g0), 64'd0);
        cyc();
        chk("rel_gnt_edge1", 64'(g0), 64'd0);
        cyc();
        chk("rel_gnt_edge2", 64'(g0), 64'd1);

        set1(0, 0, 4'h0, 12'h000, 32'h0);
        set0(1, 1, 4'b0101, 12'h010, 32'hAABBCCDD);
        cyc();
        chk("wr_gnt", 64'(g0), 64'd1);
        chk("wr_ram_we", 64'(we_s), 64'h5);
        set0(1, 0, 4'h0, 12'h010, 32'h0);
        cyc();
        set0(0, 0, 4'h0, 12'h000, 32'h0);
        cyc();
        chk("rd_after_wr_rvalid", 64'(rv0), 64'd1);
        chk("rd_after_wr_data", 64'(rd0), 64'h4ABB10DD);

        for (int i = 0; i < 3; i++) begin
            set0(1, 0, 4'h0, 12'h001, 32'h0);
            set1(0, 0, 4'h0, 12'h000, 32'h0);
            cyc();
            set0(0, 0, 4'h0, 12'h000, 32'h0);
            set1(1, 0, 4'h0, 12'h002, 32'h0);
            cyc();
            if (i == 0) begin
                chk("alt_r0_rvalid", 64'({rv1, rv0}), 64'h1);
                chk("alt_r0_data", 64'(rd0), 64'h5BFE01C3);
            end
        end
        set1(0, 0, 4'h0, 12'h000, 32'h0);
        cyc();

        set0(1, 0, 4'h0, 12'h005, 32'h0);
        set1(1, 0, 4'h0, 12'h006, 32'h0);
        for (int i = 0; i < 27; i++) begin
            cyc();
            chk("starve_seq_r1", 64'(g1), 64'(i % 9 == 8));
            chk("starve_seq_r0", 64'(g0), 64'(i % 9 != 8));
        end

        repeat (5) cyc();
        r1_req = 1'b0;
        cyc();
        r1_req = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (g1) break;
            if (g0) k++;
        end
        chk("refresh_cpu_grants", 64'(k), 64'd8);
        chk("refresh_loader_won", 64'(g1), 64'd1);

        set0(1, 0, 4'h0, 12'h003, 32'h0);
        cyc();
        set0(0, 0, 4'h0, 12'h000, 32'h0);
        set1(0, 0, 4'h0, 12'h000, 32'h0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_kills_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) cyc();
        chk("starve_cnt_after_rst", 64'(dut.u_prio.starve_cnt), 64'd0);

        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (g0 || !r0_req)
                set0($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                     12'($urandom_range(0, 31)), $urandom);
            if (g1 || !r1_req)
                set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                     12'($urandom_range(0, 31)), $urandom);
            else if ($urandom_range(0, 15) == 0)
                r1_req = 1'b0;
        end
        set0(0, 0, 4'h0, 12'h000, 32'h0);
        set1(0, 0, 4'h0, 12'h000, 32'h0);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares port A (the writable port) of the 32-bit boot data memory between the CPU data bus (requester 0) and the debug/boot loader (requester 1). The memory is built from four 8-bit byte-lane dual-port RAMs with a registered read address. This block muxes address, write data and per-lane write enables, and returns read data to the owner of each accepted read. Arbitration is fixed-priority to the CPU, with a starvation guard that guarantees the loader progress.

## Interface
- ADDR, 12, word address width (matches lane RAM depth 4096)
- LANES, 4, byte lanes; data width is 8*LANES
- STARVE, 8, max consecutive CPU grants while loader waits; range 1..255

- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- r0_req / r1_req  in  1  access request, held until granted
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_be / r1_be  in  LANES  byte enables (writes only)
- r0_addr / r1_addr  in  ADDR  word address
- r0_wdata / r1_wdata  in  8*LANES  write data
- r0_gnt / r1_gnt  out  1  request accepted this cycle
- r0_rvalid / r1_rvalid  out  1  read data valid
- r0_rdata / r1_rdata  out  8*LANES  read data, zero when rvalid low
- ram_addr  out  ADDR  to all lane RAM port A addresses
- ram_we  out  LANES  per-lane write enable
- ram_wdata  out  8*LANES  lane i gets bits [8i+7:8i]
- ram_rdata  in  8*LANES  concatenated lane port A read data

## Operation
- A transfer is accepted in any cycle with rN_req=1 and rN_gnt=1; at most one gnt per cycle.
- Requesters hold req, we, be, addr and wdata stable until gnt. They may drop req without a grant (no side effect).
- Arbitration:
  - Only one requester asserting req: it is granted.
  - Both asserting req: r0 wins unless starve_cnt == STARVE, in which case r1 wins.
- starve_cnt:
  - Increments when r0 is granted while r1_req=1.
  - Clears when r1 is granted or r1_req=0.
  - Saturates at STARVE.
  - Width is clog2(STARVE+1).
- RAM drive, from the granted requester:
  - ram_addr = granted addr. When idle it holds the last granted address; the reset value is 0.
  - ram_we = be & {LANES{we & gnt}}.
  - ram_wdata = granted wdata.
- A write with be=0 is accepted and acts as a no-op.
- An accepted read sets rd_pending=1 and rd_owner=requester for the next cycle. In that cycle the owner's rvalid=1 and its rdata=ram_rdata.
- Back-to-back reads are allowed every cycle, including alternating owners.
- Read of an address written in the immediately preceding cycle returns the new data (lane RAM port A is read-after-write).
- Reset (async assert, anytime): gnt, rvalid, ram_we and rdata are driven 0 immediately; starve_cnt=0, rd_pending=0, ram_addr=0. An in-flight read is discarded and no rvalid is issued.
- Reset release is synchronous to clk internally (two-flop release); the first grant is possible on the second rising edge after deassertion.

## Timing
- req → gnt and req → ram_* are combinational, so grant and RAM address/we occur in the same cycle.
- Write latency: the RAM is updated at the edge ending the grant cycle.
- Read latency: rvalid and rdata arrive exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle.
- Loader worst-case wait while the CPU requests continuously: STARVE+1 cycles.

## Structure
- Shared package bram_arb_pkg:
  - LANES and data width constants
  - requester ID enum: REQ_CPU=0, REQ_LOADER=1
  - function computing the starve counter width
- Sub-module bram_arb_prio: pure grant logic plus starve_cnt register. Inputs are the two req bits; outputs are the one-hot grant.
- Top level holds the muxes and the rd_pending/rd_owner registers.

## Test plan
- Reset: hold reset_n=0 with both req=1 → all gnt/rvalid/ram_we=0 and ram_addr=0. Release → r0 granted on the 2nd edge.
- r0 write addr 0x010, be=4'b0101, data 0xAABBCCDD, then read 0x010 next cycle → ram_we=0101. Read returns 0x??BB??DD: lanes 1/3 hold their preload, lanes 0/2 hold the new bytes.
- Both req continuous, STARVE=8 → grant sequence r0×8, r1×1, repeating. r1 never waits more than 9 cycles.
- Alternating reads r0@0x001, r1@0x002 back-to-back → each rvalid asserts one cycle after its own grant with the correct data, and never to the wrong requester.
- Async reset asserted in the cycle after a read grant → no rvalid, and starve_cnt=0 after release.
- r1 drops req mid-wait after 5 CPU grants → starve_cnt clears to 0. On re-request it needs a fresh 8 CPU grants before winning.
